uart_rx_fifo: RTL and testbench

// - Synchronous show-ahead FIFO holding received UART characters plus per-character status bits.
// - Sits between the UART receiver state machine (push side) and the register/bus interface (pop side).
// - Reports fill level, overrun (push while full), and an aggregate error flag for the LSR.

---
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO for the UART: character plus break/parity/framing status per entry.
// Define UART_FIFO_ERROR_BIT_EN to build per-entry status tracking behind error_bit.
module uart_rx_fifo #(
  parameter int WIDTH     = 11,
  parameter int DEPTH     = 16,
  parameter int POINTER_W = 4,
  parameter int COUNTER_W = 5
) (
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  input  logic                 push,
  input  logic                 pop,
  output logic                 overrun,
  output logic [COUNTER_W-1:0] count,
  output logic                 error_bit,
  input  logic                 fifo_reset,
  input  logic                 reset_status
);

  localparam logic [COUNTER_W-1:0] FULL_CNT = COUNTER_W'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [POINTER_W-1:0] wr_ptr, rd_ptr;
  logic                 full, empty, do_push, do_pop, overflow;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_pop   = pop  & ~fifo_reset & ~empty;
  assign do_push  = push & ~fifo_reset & (~full | pop);
  assign overflow = push & ~fifo_reset & full & ~pop;

  assign data_out = mem[rd_ptr];

  // Character storage carries no reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (!wb_rst_i && do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (fifo_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + POINTER_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + POINTER_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNTER_W'(1);
        2'b01:   count <= count - COUNTER_W'(1);
        default: count <= count;
      endcase
      // A dropped push outranks a simultaneous clear request.
      overrun <= overflow | (overrun & ~reset_status);
    end
  end

`ifdef UART_FIFO_ERROR_BIT_EN
  logic [2:0] stat [DEPTH];

  // Vacated slots are cleared on pop so the OR covers only valid entries;
  // the write comes last so a push into the slot being popped keeps its status.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) stat[i] <= 3'b000;
    end else if (fifo_reset) begin
      for (int i = 0; i < DEPTH; i++) stat[i] <= 3'b000;
    end else begin
      if (do_pop)  stat[rd_ptr] <= 3'b000;
      if (do_push) stat[wr_ptr] <= data_in[2:0];
    end
  end

  always_comb begin
    error_bit = 1'b0;
    for (int i = 0; i < DEPTH; i++) error_bit = error_bit | (|stat[i]);
  end
`else
  assign error_bit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner sequences, randomized run vs queue model.
module tb_uart_rx_fifo;

`ifdef UART_FIFO_ERROR_BIT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk, wb_rst_i;
  logic [10:0] data_in, data_out;
  logic        push, pop, overrun, error_bit, fifo_reset, reset_status;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  logic [10:0] q[$];
  bit          m_ovr;

  uart_rx_fifo dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .data_in(data_in), .data_out(data_out),
    .push(push), .pop(pop), .overrun(overrun), .count(count),
    .error_bit(error_bit), .fifo_reset(fifo_reset), .reset_status(reset_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p, po, fr;
    logic [10:0] d;
    int          cnt;
    logic [10:0] dout;
    bit          chk_dout;
    bit          err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: queue of entries, applying the push/pop/flush rules directly.
  task automatic step(input logic p, input logic po, input logic fr, input logic rs,
                      input logic [10:0] d);
    bit ovf;
    push = p; pop = po; fifo_reset = fr; reset_status = rs; data_in = d;
    ovf = 1'b0;
    if (fr) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      if (p && po && q.size() > 0) begin
        q.push_back(d);
        void'(q.pop_front());
      end else if (p && q.size() < 16) begin
        q.push_back(d);
      end else if (p) begin
        ovf = 1'b1;
      end else if (po && q.size() > 0) begin
        void'(q.pop_front());
      end
      m_ovr = ovf ? 1'b1 : (rs ? 1'b0 : m_ovr);
    end
    @(posedge clk); #1;
    push = 0; pop = 0; fifo_reset = 0; reset_status = 0;
  endtask

  function automatic bit model_err();
    bit e = 1'b0;
    foreach (q[i]) e |= |q[i][2:0];
    return e & ERR_EN;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".error_bit"}, 32'(error_bit), 32'(model_err()));
    if (q.size() > 0) chk({tag, ".data_out"}, 32'(data_out), 32'(q[0]));
  endtask

  vec_t tbl[12];

  initial begin
    push = 0; pop = 0; fifo_reset = 0; reset_status = 0; data_in = '0;
    m_ovr = 0;
    wb_rst_i = 1'b1;
    #3;
    chk("reset.count", 32'(count), 0);
    chk("reset.overrun", 32'(overrun), 0);
    chk("reset.error_bit", 32'(error_bit), 0);
    #9 wb_rst_i = 1'b0;

    //          p   po  fr  data    cnt dout    chk err
    tbl[0]  = '{1, 0, 0, 11'h0A8, 1, 11'h0A8, 1, 0};
    tbl[1]  = '{1, 0, 0, 11'h004, 2, 11'h0A8, 1, 1};
    tbl[2]  = '{1, 0, 0, 11'h0A0, 3, 11'h0A8, 1, 1};
    tbl[3]  = '{0, 1, 0, 11'h000, 2, 11'h004, 1, 1};
    tbl[4]  = '{0, 1, 0, 11'h000, 1, 11'h0A0, 1, 0};
    tbl[5]  = '{1, 1, 0, 11'h118, 1, 11'h118, 1, 0};
    tbl[6]  = '{0, 1, 0, 11'h000, 0, 11'h000, 0, 0};
    tbl[7]  = '{0, 1, 0, 11'h000, 0, 11'h000, 0, 0};
    tbl[8]  = '{1, 1, 0, 11'h0F2, 1, 11'h0F2, 1, 1};
    tbl[9]  = '{1, 0, 0, 11'h3F8, 2, 11'h0F2, 1, 1};
    tbl[10] = '{1, 0, 1, 11'h7FF, 0, 11'h000, 0, 0};
    tbl[11] = '{1, 0, 0, 11'h055, 1, 11'h055, 1, 1};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].p, tbl[i].po, tbl[i].fr, 1'b0, tbl[i].d);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.error_bit", i), 32'(error_bit), 32'(tbl[i].err & ERR_EN));
      if (tbl[i].chk_dout) chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(tbl[i].dout));
    end
    step(0, 0, 1, 0, '0);

    // Fill, then overflow with 0x7FF; first entry must still be at the head.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 11'(8 * i + 8));
    step(1, 0, 0, 0, 11'h7FF);
    chk("full.count", 32'(count), 16);
    chk("full.overrun", 32'(overrun), 1);
    chk("full.data_out", 32'(data_out), 32'h008);
    step(0, 0, 0, 1, '0);
    chk("rs.overrun", 32'(overrun), 0);

    // Overflow coinciding with reset_status leaves overrun set.
    step(1, 0, 0, 1, 11'h7FF);
    chk("ovf_rs.overrun", 32'(overrun), 1);
    step(0, 0, 0, 1, '0);

    // Full push+pop: count holds, no overrun, new entry surfaces after 15 pops.
    step(1, 1, 0, 0, 11'h5A8);
    chk("fullpp.count", 32'(count), 16);
    chk("fullpp.overrun", 32'(overrun), 0);
    chk("fullpp.data_out", 32'(data_out), 32'h010);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, '0);
    chk("fullpp.emerge", 32'(data_out), 32'h5A8);
    chk("fullpp.count1", 32'(count), 1);

    // Flush with push asserted drops everything including errors.
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 11'(8 * i + 1));
    step(1, 0, 0, 1, '0);
    step(1, 0, 1, 0, 11'h007);
    chk("flush.count", 32'(count), 0);
    chk("flush.overrun", 32'(overrun), 0);
    chk("flush.error_bit", 32'(error_bit), 0);
    check_model("flush.model");

    // Randomized run with alternating fill-heavy and drain-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      logic [10:0] d;
      int pp;
      pp = ((n / 200) % 2 == 0) ? 75 : 30;
      d = 11'($urandom);
      if ($urandom_range(0, 7) != 0) d[2:0] = 3'b000;
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < 50,
           $urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0, d);
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
